// File: rtl/uart_rx.sv
// 8N1 UART receiver with 2-flop input synchronizer and a small byte FIFO.
// Sticky overrun/frame_error flags and a per-byte interrupt pulse.
module uart_rx #(
    parameter int unsigned CLK_HZ     = 27_000_000,
    parameter int unsigned BAUD       = 115_200,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         rx,
    input  logic                         r_enable,
    output logic [7:0]                   r_data,
    output logic                         available,
    output logic [$clog2(FIFO_DEPTH):0]  count,
    input  logic                         clear_errors,
    output logic                         overrun,
    output logic                         frame_error,
    input  logic                         interrupt_enable,
    output logic                         interrupt
);

    localparam int unsigned CLKS_PER_BIT = CLK_HZ / BAUD;
    localparam int unsigned TW = $clog2(CLKS_PER_BIT);
    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [TW-1:0] HALF_LAST  = TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TW-1:0] BIT_LAST   = TW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    logic          rx_meta;
    logic          rx_s;
    state_t        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          stop_ok;
    logic          stop_bad;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] head_ptr_next;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_next;
    logic          full;
    logic          pop;
    logic          push;
    logic          drop;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            timer_q <= '0;
            bit_q   <= '0;
            shift_q <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q + 1'b1;
        bit_d    = bit_q;
        shift_d  = shift_q;
        stop_ok  = 1'b0;
        stop_bad = 1'b0;
        case (state_q)
            IDLE: begin
                timer_d = '0;
                if (!rx_s) state_d = START;
            end
            START: begin
                // Mid-start-bit recheck rejects short low glitches.
                if (timer_q == HALF_LAST) begin
                    timer_d = '0;
                    if (rx_s) begin
                        state_d = IDLE;
                    end else begin
                        state_d = DATA;
                        bit_d   = '0;
                    end
                end
            end
            DATA: begin
                if (timer_q == BIT_LAST) begin
                    timer_d = '0;
                    shift_d = {rx_s, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) state_d = STOP;
                end
            end
            STOP: begin
                if (timer_q == BIT_LAST) begin
                    timer_d = '0;
                    state_d = IDLE;
                    if (rx_s) stop_ok  = 1'b1;
                    else      stop_bad = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign full = (count_q == FULL_COUNT);
    assign pop  = r_enable && (count_q != '0);
    assign push = stop_ok && (!full || pop);
    assign drop = stop_ok && full && !pop;
    assign head_ptr_next = pop ? rd_ptr + 1'b1 : rd_ptr;

    always_comb begin
        count_next = count_q;
        if (push && !pop)      count_next = count_q + 1'b1;
        else if (pop && !push) count_next = count_q - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= shift_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count_q     <= '0;
            r_data      <= '0;
            interrupt   <= 1'b0;
            overrun     <= 1'b0;
            frame_error <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            rd_ptr  <= head_ptr_next;
            count_q <= count_next;
            // Registered head: bypass the incoming byte when it lands in the head slot.
            if (count_next != '0) begin
                if (push && head_ptr_next == wr_ptr) r_data <= shift_q;
                else                                 r_data <= mem[head_ptr_next];
            end
            interrupt <= push && interrupt_enable;
            if (drop)              overrun <= 1'b1;
            else if (clear_errors) overrun <= 1'b0;
            if (stop_bad)          frame_error <= 1'b1;
            else if (clear_errors) frame_error <= 1'b0;
        end
    end

    assign count     = count_q;
    assign available = (count_q != '0);

endmodule
